// File: rtl/joy_db15_tx.sv
// DB15 joystick serial transmitter: emulates the adapter's parallel-in/serial-out
// chain so two player words can be shifted to the host over joy_load/joy_clk/joy_data.
//
// state | meaning
// IDLE  | after reset, waiting for the first load; output held at 1
// LOAD  | load held low, snapshotting both player words every cycle
// SHIFT | one bit per filtered joy_clk rise, player 1 LSB first
// DONE  | frame fully consumed; output 1 until the next load
module joy_db15_tx #(
  parameter int NBITS  = 16,
  parameter int FILTER = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             joy_clk,
  input  logic             joy_load,
  input  logic [NBITS-1:0] joystick1,
  input  logic [NBITS-1:0] joystick2,
  output logic             joy_data,
  output logic             frame_done,
  output logic             short_frame,
  output logic [7:0]       frame_count
);
  localparam int TOT = 2 * NBITS;
  localparam int CW  = $clog2(TOT) + 1;
  localparam int FW  = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TOT - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state;
  logic [TOT-1:0] sr;
  logic [CW-1:0]  cnt;

  // bit 0 carries joy_clk, bit 1 carries joy_load
  logic [1:0]    pin, sync1, sync2, flt, flt_d;
  logic [FW-1:0] fcnt [2];
  logic          clk_rise, load_fall, load_rise;

  assign pin = {joy_load, joy_clk};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '1;
      sync2   <= '1;
      flt     <= '1;
      flt_d   <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      flt_d <= flt;
      // a level change is accepted only after FILTER consecutive differing samples
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_LAST) begin
          flt[i]  <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign clk_rise  = flt[0] & ~flt_d[0];
  assign load_fall = flt_d[1] & ~flt[1];
  assign load_rise = flt[1] & ~flt_d[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '1;
      cnt         <= '0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      // load fall wins over everything, including a coincident clk rise
      if (load_fall) begin
        if (state == SHIFT && cnt != '0) short_frame <= 1'b1;
        state <= LOAD;
        sr    <= {~joystick2, ~joystick1};
        cnt   <= '0;
      end else begin
        case (state)
          LOAD: begin
            if (load_rise) begin
              state <= SHIFT;
            end else begin
              sr  <= {~joystick2, ~joystick1};
              cnt <= '0;
            end
          end
          SHIFT: begin
            if (clk_rise) begin
              sr  <= {1'b1, sr[TOT-1:1]};
              cnt <= cnt + CW'(1);
              if (cnt == CNT_LAST) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
                state       <= DONE;
              end
            end
          end
          DONE:    sr <= '1;
          default: ;
        endcase
      end
    end
  end

  assign joy_data = sr[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: frame-level model fed by host pin events, checked every cycle,
// plus literal stream/counter expectations and a small-word instance for counter wrap.
module tb_joy_db15_tx;
  localparam int N   = 16;
  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         joy_clk = 1'b1, joy_load = 1'b1;
  logic [N-1:0] joystick1 = '0, joystick2 = '0;
  logic         joy_data, frame_done, short_frame;
  logic [7:0]   frame_count;

  logic         s_clk = 1'b1, s_load = 1'b1;
  logic [1:0]   s_j1 = 2'b01, s_j2 = 2'b10;
  logic         s_data, s_done, s_short;
  logic [7:0]   s_count;

  joy_db15_tx #(.NBITS(N), .FILTER(3)) u_dut (
    .clk(clk), .reset(reset), .joy_clk(joy_clk), .joy_load(joy_load),
    .joystick1(joystick1), .joystick2(joystick2), .joy_data(joy_data),
    .frame_done(frame_done), .short_frame(short_frame), .frame_count(frame_count));

  joy_db15_tx #(.NBITS(2), .FILTER(3)) u_small (
    .clk(clk), .reset(reset), .joy_clk(s_clk), .joy_load(s_load),
    .joystick1(s_j1), .joystick2(s_j2), .joy_data(s_data),
    .frame_done(s_done), .short_frame(s_short), .frame_count(s_count));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int done_seen = 0, short_seen = 0, s_done_seen = 0, s_short_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // frame-level model: pin transitions become events that take effect LAT cycles later
  typedef enum {M_IDLE, M_LOAD, M_SHIFT, M_DONE} mstate_t;
  mstate_t      m_state = M_IDLE;
  logic [2*N-1:0] m_bits = '1;
  int           m_k = 0, m_count = 0;
  int           ev_due[$], ev_kind[$];   // kind 0 load fall, 1 load rise, 2 clk rise

  task automatic post(int kind);
    ev_due.push_back(cyc + LAT);
    ev_kind.push_back(kind);
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_k     = 0;
    m_count = 0;
    ev_due.delete();
    ev_kind.delete();
  endtask

  logic f_ev, r_ev, c_ev, e_done, e_short, e_data;
  always @(negedge clk) begin
    f_ev = 0; r_ev = 0; c_ev = 0; e_done = 0; e_short = 0;
    while (ev_due.size() > 0 && ev_due[0] <= cyc) begin
      case (ev_kind[0])
        0:       f_ev = 1;
        1:       r_ev = 1;
        default: c_ev = 1;
      endcase
      void'(ev_due.pop_front());
      void'(ev_kind.pop_front());
    end
    if (f_ev) begin
      if (m_state == M_SHIFT && m_k > 0) e_short = 1;
      m_state = M_LOAD;
      m_bits  = ~{joystick2, joystick1};
      m_k     = 0;
    end else if (r_ev) begin
      if (m_state == M_LOAD) m_state = M_SHIFT;
    end else if (c_ev && m_state == M_SHIFT) begin
      m_k++;
      if (m_k == 2 * N) begin
        e_done  = 1;
        m_count = (m_count + 1) % 256;
        m_state = M_DONE;
      end
    end
    e_data = (m_state == M_LOAD || m_state == M_SHIFT) ? m_bits[m_k] : 1'b1;
    check("joy_data", 64'(joy_data), 64'(e_data));
    check("frame_done", 64'(frame_done), 64'(e_done));
    check("short_frame", 64'(short_frame), 64'(e_short));
    check("frame_count", 64'(frame_count), 64'(m_count));
    if (frame_done === 1'b1) done_seen++;
    if (short_frame === 1'b1) short_seen++;
    if (s_done === 1'b1) s_done_seen++;
    if (s_short === 1'b1) s_short_seen++;
  end

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pulse(logic [N-1:0] j1, logic [N-1:0] j2);
    @(negedge clk);
    joystick1 = j1; joystick2 = j2;
    joy_load = 1'b0; post(0);
    wait_n(10);
    joy_load = 1'b1; post(1);
  endtask

  task automatic clk_pulse(output logic b);
    @(negedge clk);
    joy_clk = 1'b0;
    wait_n(10);
    b = joy_data;
    joy_clk = 1'b1; post(2);
    wait_n(9);
  endtask

  task automatic shift_bits(int from, int upto, inout logic [2*N-1:0] st);
    logic b;
    for (int i = from; i < upto; i++) begin
      clk_pulse(b);
      st[i] = b;
    end
  endtask

  task automatic s_frame(output logic [3:0] st);
    @(negedge clk);
    s_load = 1'b0;
    wait_n(7);
    s_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_clk = 1'b0;
      wait_n(7);
      st[i] = s_data;
      s_clk = 1'b1;
      wait_n(6);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [2*N-1:0] st;
  logic [3:0]     sst;
  initial begin
    #1 reset = 1'b1;
    wait_n(3);
    reset = 1'b0;

    // reset idle
    wait_n(100);
    check("idle joy_data", 64'(joy_data), 64'd1);
    check("idle frame_count", 64'(frame_count), 64'd0);
    check("idle pulses", 64'(done_seen + short_seen), 64'd0);

    // full frame
    st = '1;
    load_pulse(16'h0A51, 16'h8003);
    shift_bits(0, 32, st);
    wait_n(12);
    check("full stream", 64'(st), 64'h7FFCF5AE);
    check("full done pulses", 64'(done_seen), 64'd1);
    check("full frame_count", 64'(frame_count), 64'd1);
    check("full idle after", 64'(joy_data), 64'd1);

    // glitches on both lines mid-frame
    st = '1;
    load_pulse(16'h1234, 16'hBEEF);
    shift_bits(0, 4, st);
    @(negedge clk); joy_clk = 1'b0; wait_n(2); joy_clk = 1'b1; wait_n(10);
    joy_load = 1'b0; wait_n(2); joy_load = 1'b1; wait_n(10);
    shift_bits(4, 32, st);
    wait_n(12);
    check("glitch stream", 64'(st), 64'h4110EDCB);
    check("glitch short", 64'(short_seen), 64'd0);
    check("glitch frame_count", 64'(frame_count), 64'd2);

    // abort after 5 bits, then a fresh frame
    st = '1;
    load_pulse(16'hFFFF, 16'h0000);
    shift_bits(0, 5, st);
    check("abort count before", 64'(frame_count), 64'd2);
    st = '1;
    load_pulse(16'h00F0, 16'hA5A5);
    shift_bits(0, 32, st);
    wait_n(12);
    check("abort short pulses", 64'(short_seen), 64'd1);
    check("abort restart stream", 64'(st), 64'h5A5AFF0F);
    check("abort frame_count", 64'(frame_count), 64'd3);

    // load fall and clk rise on the same edge
    st = '1;
    load_pulse(16'h0F0F, 16'h3C3C);
    shift_bits(0, 3, st);
    @(negedge clk); joy_clk = 1'b0;
    wait_n(10);
    joystick1 = 16'hC001; joystick2 = 16'h7E57;
    joy_load = 1'b0; joy_clk = 1'b1; post(0); post(2);
    wait_n(10);
    joy_load = 1'b1; post(1);
    st = '1;
    shift_bits(0, 32, st);
    wait_n(12);
    check("simul stream", 64'(st), 64'h81A83FFE);
    check("simul short pulses", 64'(short_seen), 64'd2);
    check("simul frame_count", 64'(frame_count), 64'd4);

    // reset at bit 17
    st = '1;
    load_pulse(16'h5555, 16'hAAAA);
    shift_bits(0, 17, st);
    check("pre-reset bit17", 64'(joy_data), 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset joy_data", 64'(joy_data), 64'd1);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset short_frame", 64'(short_frame), 64'd0);
    check("reset frame_count", 64'(frame_count), 64'd0);
    wait_n(3);
    reset = 1'b0;
    wait_n(5);
    st = '1;
    load_pulse(16'h8001, 16'h0100);
    shift_bits(0, 32, st);
    wait_n(12);
    check("post-reset stream", 64'(st), 64'hFEFF7FFE);
    check("post-reset frame_count", 64'(frame_count), 64'd1);

    // frame counter wrap on the 2-bit-word instance
    s_done_seen = 0;
    s_frame(sst);
    check("small stream", 64'(sst), 64'h6);
    for (int f = 1; f < 255; f++) s_frame(sst);
    wait_n(20);
    check("small count 255", 64'(s_count), 64'd255);
    s_frame(sst);
    wait_n(20);
    check("small count wrap", 64'(s_count), 64'd0);
    check("small done pulses", 64'(s_done_seen), 64'd256);
    check("small short pulses", 64'(s_short_seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Serial transmitter side of the DB15 UserIO joystick link. It emulates the adapter's parallel-in/serial-out shift-register chain, so a core (or a loopback bench) can drive two 16-bit player words back into `joy_db15` over the same three wires. It snapshots both joystick words on the load pulse and shifts them out, LSB of player 1 first, on host clock edges. It sits between the board-level USER_IN/USER_OUT pins and any controller-source logic.

## Interface
- `NBITS`, 16: bits per player word; frame length is 2*NBITS.
- `FILTER`, 3: consecutive identical synchronized samples needed to accept a level change on `joy_clk`/`joy_load` (≥1).
- `clk`  in  1  system clock (40–50 MHz); only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `joy_clk`  in  1  host shift clock, asynchronous to `clk`, idle high.
- `joy_load`  in  1  host parallel-load strobe, asynchronous, active-low.
- `joystick1`  in  NBITS  player 1 buttons, active-high, bit layout LS FEDCBAUDLR.
- `joystick2`  in  NBITS  player 2 buttons, same layout.
- `joy_data`  out  1  serial data to host, active-low per bit (pressed = 0), idle 1.
- `frame_done`  out  1  one-cycle pulse when the last bit has been consumed.
- `short_frame`  out  1  one-cycle pulse when a load aborts a partially shifted frame.
- `frame_count`  out  8  completed frames, wraps 255→0.

## Operation
- Input path: `joy_clk` and `joy_load` each go through a 2-FF synchronizer (reset to 1), then a glitch filter. The filtered level flips only after FILTER consecutive synchronized samples differ from it. Filtered levels reset to 1. Edges are detected on the filtered levels.
- Shift register `sr` is 2*NBITS wide and resets to all 1s. `joy_data` = `sr[0]`, registered.
- States:
  - IDLE (reset state): clk edges are ignored; `joy_data` = 1.
  - LOAD: entered on a filtered `joy_load` fall from any state. While the filtered load is low, every cycle: `sr` ← {~joystick2, ~joystick1}, `cnt` ← 0, clk edges are ignored. The frame carries the last value captured before load rises.
  - SHIFT: entered on a filtered `joy_load` rise from LOAD. Each filtered `joy_clk` rising edge does `sr` ← {1'b1, sr[2N-1:1]} and `cnt`++. When `cnt` reaches 2*NBITS, the block pulses `frame_done`, increments `frame_count` (mod 256) and goes to DONE.
  - DONE: `sr` is all 1s, so `joy_data` = 1. Clk edges are ignored. Only a load exits this state.
- A filtered load fall in SHIFT with 1 ≤ `cnt` ≤ 2*NBITS−1 pulses `short_frame` and re-enters LOAD. It does not increment `frame_count`.
- A load fall in SHIFT with `cnt` = 0 is not short.
- A filtered load fall and a filtered clk rise in the same cycle: load wins and the clk edge is discarded.
- `cnt` width is clog2(2*NBITS)+1 bits. It saturates at 2*NBITS and never wraps mid-frame.
- Reset asserted mid-frame: all state returns to reset values immediately (async), output `joy_data` = 1. After release the block waits in IDLE for a load.

## Timing
- Reset values: `joy_data` = 1, `frame_done` = 0, `short_frame` = 0, `frame_count` = 0, state IDLE.
- Pin-to-filtered-edge latency is 2 + FILTER `clk` cycles. `joy_data` updates one cycle later, giving 3 + FILTER cycles total (6 at FILTER=3).
- The host must keep each `joy_clk` phase and the `joy_load` low pulse ≥ FILTER+3 `clk` cycles, and sample `joy_data` ≥ FILTER+4 cycles after its falling→rising transition.
- Pulses shorter than FILTER samples after synchronization are rejected entirely.
- Bit k (0-based) of the frame is on `joy_data` from the update after load rise (k=0) or after the k-th clk rise, until the next update. Bits 0..N−1 are ~joystick1[0..N−1]; bits N..2N−1 are ~joystick2[0..N−1].
- `frame_done` is asserted in the same cycle `sr`/`joy_data` show the 2N-th shift.

## Test plan
- **Reset idle:** reset, inputs high, 100 cycles → `joy_data` = 1, no pulses, `frame_count` = 0.
- **Full frame:** `joystick1` = 16'h0A51, `joystick2` = 16'h8003, load low 10 cycles then high, 32 clk pulses of 10 cycles per phase.
  - Serial stream equals ~16'h0A51 LSB-first, then ~16'h8003 LSB-first.
  - Exactly one `frame_done` pulse, coincident with the 32nd shift; `frame_count` = 1.
  - `joy_data` = 1 afterwards.
- **Glitch rejection:** during SHIFT, 2-cycle low glitches on `joy_clk` and `joy_load` → no shift, no reload, bit stream unchanged.
- **Abort:** load, 5 clk pulses, load again → one `short_frame` pulse, `frame_count` unchanged. The next full frame restarts at bit 0 with fresh joystick values.
- **Simultaneous edges:** host drives the `joy_load` fall and a `joy_clk` rise on the same `clk` edge → reload occurs, no shift, `cnt` = 0.
- **Counter and reset:** run 256 frames → `frame_count` wraps to 0. Assert reset at bit 17 → outputs return to reset values within the same cycle; the next load/shift frame is correct.
